// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the Minisys-1A CPU: walks each instruction through
// IF/ID/EXE/MEM/WB, splits memory from IO by address window and diverts to a trap state.
module multicycle_control #(
  parameter int unsigned IO_HIGH_W   = 22,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned IRQ_LINES   = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 imem_ready,
  input  logic [IO_HIGH_W-1:0] alu_result_high,
  input  logic                 mem_ready,
  input  logic [IRQ_LINES-1:0] int_req,
  input  logic                 int_enable,
  output logic [2:0]           state,
  output logic                 pc_write,
  output logic                 branch_cond,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 trap,
  output logic [2:0]           trap_cause,
  output logic                 eret
);

  localparam int unsigned      CNT_W        = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] CAUSE_INT      = 3'd0;
  localparam logic [2:0] CAUSE_SYSCALL  = 3'd1;
  localparam logic [2:0] CAUSE_BREAK    = 3'd2;
  localparam logic [2:0] CAUSE_RESERVED = 3'd3;
  localparam logic [2:0] CAUSE_BUSERR   = 3'd4;

  typedef enum logic [2:0] {
    SINIT = 3'd0,
    SIF   = 3'd1,
    SID   = 3'd2,
    SEXE  = 3'd3,
    SMEM  = 3'd4,
    SWB   = 3'd5,
    STRAP = 3'd6
  } state_e;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic wr_reg;
    logic reserved;
    logic syscall;
    logic brk;
    logic eret;
  } class_t;

  state_e           cur, nxt;
  logic [31:0]      ir, ir_nxt;
  class_t           flg, dn;
  logic             is_io, io_n;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [2:0]       cause_nxt;
  logic             irq_pend, mem_done;
  state_e           retire_st;
  logic [2:0]       retire_cause;
  logic             pc_write_q;
  logic             pcw_n;
  logic [5:0]       op, fn;
  logic [4:0]       rs, rt;

  assign state    = cur;
  assign ir_write = (cur == SIF) && imem_ready && !reset;
  assign ir_nxt   = ir_write ? instruction : ir;
  assign irq_pend = (|int_req) && int_enable;
  assign mem_done = is_io || mem_ready;
  // Only the store completion in SMEM reaches pc_write combinationally.
  assign pc_write = pc_write_q || ((cur == SMEM) && flg.store && mem_done && !reset);

  assign op = ir_nxt[31:26];
  assign rs = ir_nxt[25:21];
  assign rt = ir_nxt[20:16];
  assign fn = ir_nxt[5:0];

  // Instruction class decode of the word that IR holds next cycle.
  always_comb begin
    dn = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:                        dn.wr_reg = 1'b1;
          6'h08:                               dn.jump = 1'b1;
          6'h09: begin
            dn.jump   = 1'b1;
            dn.link   = 1'b1;
            dn.wr_reg = 1'b1;
          end
          6'h0C:                               dn.syscall = 1'b1;
          6'h0D:                               dn.brk = 1'b1;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: ;
          default:                             dn.reserved = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: dn.branch = 1'b1;
          5'h10, 5'h11: begin
            dn.branch = 1'b1;
            dn.link   = 1'b1;
            dn.wr_reg = 1'b1;
          end
          default:      dn.reserved = 1'b1;
        endcase
      end
      6'h02: dn.jump = 1'b1;
      6'h03: begin
        dn.jump   = 1'b1;
        dn.link   = 1'b1;
        dn.wr_reg = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: dn.branch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: dn.wr_reg = 1'b1;
      6'h10: begin
        if (rs == 5'h00)                     dn.wr_reg = 1'b1;
        else if (rs == 5'h04)                dn.wr_reg = 1'b0;
        else if (rs == 5'h10 && fn == 6'h18) dn.eret = 1'b1;
        else                                 dn.reserved = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dn.load   = 1'b1;
        dn.wr_reg = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: dn.store = 1'b1;
      default: dn.reserved = 1'b1;
    endcase
  end

  // Next state; every retirement into SIF is where a pending interrupt is taken.
  always_comb begin
    nxt          = cur;
    cause_nxt    = trap_cause;
    cnt_nxt      = '0;
    io_n         = is_io;
    retire_st    = irq_pend ? STRAP : SIF;
    retire_cause = irq_pend ? CAUSE_INT : trap_cause;
    case (cur)
      SINIT: nxt = SIF;
      SIF:   if (imem_ready) nxt = SID;
      SID: begin
        if (flg.syscall) begin
          nxt       = STRAP;
          cause_nxt = CAUSE_SYSCALL;
        end else if (flg.brk) begin
          nxt       = STRAP;
          cause_nxt = CAUSE_BREAK;
        end else if (flg.reserved) begin
          nxt       = STRAP;
          cause_nxt = CAUSE_RESERVED;
        end else if (flg.jump && flg.link) begin
          nxt = SWB;
        end else if (flg.jump || flg.eret) begin
          nxt       = retire_st;
          cause_nxt = retire_cause;
        end else begin
          nxt = SEXE;
        end
      end
      SEXE: begin
        io_n = &alu_result_high;
        if (flg.branch && flg.link) begin
          nxt = SWB;
        end else if (flg.branch) begin
          nxt       = retire_st;
          cause_nxt = retire_cause;
        end else if (flg.load || flg.store) begin
          nxt = SMEM;
        end else if (flg.wr_reg) begin
          nxt = SWB;
        end else begin
          nxt       = retire_st;
          cause_nxt = retire_cause;
        end
      end
      SMEM: begin
        if (mem_done) begin
          if (flg.load) begin
            nxt = SWB;
          end else begin
            nxt       = retire_st;
            cause_nxt = retire_cause;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          nxt       = STRAP;
          cause_nxt = CAUSE_BUSERR;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      SWB: begin
        nxt       = retire_st;
        cause_nxt = retire_cause;
      end
      STRAP:   nxt = SIF;
      default: nxt = SINIT;
    endcase
  end

  // PC load for the state being entered; branches already loaded PC in SEXE.
  always_comb begin
    pcw_n = 1'b0;
    case (nxt)
      SID:     pcw_n = (dn.jump && !dn.link) || dn.eret;
      SEXE:    pcw_n = dn.branch || !(dn.load || dn.store || dn.wr_reg);
      SWB:     pcw_n = !dn.branch;
      STRAP:   pcw_n = 1'b1;
      default: pcw_n = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= SINIT;
      ir          <= '0;
      flg         <= '0;
      is_io       <= 1'b0;
      wait_cnt    <= '0;
      trap_cause  <= CAUSE_INT;
      pc_write_q  <= 1'b0;
      branch_cond <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      io_read     <= 1'b0;
      io_write    <= 1'b0;
      trap        <= 1'b0;
      eret        <= 1'b0;
    end else begin
      cur         <= nxt;
      ir          <= ir_nxt;
      flg         <= dn;
      is_io       <= io_n;
      wait_cnt    <= cnt_nxt;
      trap_cause  <= cause_nxt;
      pc_write_q  <= pcw_n;
      branch_cond <= (nxt == SEXE) && dn.branch;
      reg_write   <= (nxt == SWB);
      mem_read    <= (nxt == SMEM) && dn.load && !io_n;
      mem_write   <= (nxt == SMEM) && dn.store && !io_n;
      io_read     <= (nxt == SMEM) && dn.load && io_n;
      io_write    <= (nxt == SMEM) && dn.store && io_n;
      trap        <= (nxt == STRAP);
      eret        <= (nxt == SID) && dn.eret;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction classes cycle by cycle
// against hand-derived state/strobe sequences.
module tb_multicycle_control;
  localparam int unsigned IO_HIGH_W   = 22;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned IRQ_LINES   = 6;

  localparam logic [31:0] ADD_I   = 32'h0043_0820;
  localparam logic [31:0] LW_I    = 32'h8C05_0010;
  localparam logic [31:0] SW_I    = 32'hAC05_FC60;
  localparam logic [31:0] RSV_I   = 32'hFC00_0000;
  localparam logic [31:0] J_I     = 32'h0800_0010;
  localparam logic [31:0] BEQ_I   = 32'h1022_0004;
  localparam logic [31:0] SYS_I   = 32'h0000_000C;
  localparam logic [31:0] ERET_I  = 32'h4200_0018;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          instruction;
  logic                 imem_ready;
  logic [IO_HIGH_W-1:0] alu_result_high;
  logic                 mem_ready;
  logic [IRQ_LINES-1:0] int_req;
  logic                 int_enable;
  logic [2:0]           state;
  logic                 pc_write, branch_cond, ir_write, reg_write;
  logic                 mem_read, mem_write, io_read, io_write, trap, eret;
  logic [2:0]           trap_cause;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  multicycle_control #(
    .IO_HIGH_W(IO_HIGH_W), .MEM_TIMEOUT(MEM_TIMEOUT), .IRQ_LINES(IRQ_LINES)
  ) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .imem_ready(imem_ready),
    .alu_result_high(alu_result_high), .mem_ready(mem_ready), .int_req(int_req),
    .int_enable(int_enable), .state(state), .pc_write(pc_write), .branch_cond(branch_cond),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .io_read(io_read), .io_write(io_write), .trap(trap), .trap_cause(trap_cause), .eret(eret)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; instruction = '0; imem_ready = 1'b0; alu_result_high = '0;
    mem_ready = 1'b0; int_req = '0; int_enable = 1'b0;
    cyc(); cyc(); #1;
    chk3("rst_state", state, 3'd0);
    chk1("rst_pc_write", pc_write, 1'b0);
    chk1("rst_reg_write", reg_write, 1'b0);
    chk1("rst_trap", trap, 1'b0);
    chk3("rst_cause", trap_cause, 3'd0);
    chk1("rst_ir_write", ir_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);

    reset = 1'b0;
    cyc(); #1; chk3("init_to_if", state, 3'd1); chk1("if_wait_irw", ir_write, 1'b0);
    cyc(); instruction = ADD_I; imem_ready = 1'b1; #1;
    chk3("if_hold", state, 3'd1); chk1("add_irw", ir_write, 1'b1);

    // add: IF ID EXE WB
    cyc(); #1; chk3("add_id", state, 3'd2); chk1("add_id_rw", reg_write, 1'b0);
    cyc(); #1; chk3("add_exe", state, 3'd3); chk1("add_exe_pcw", pc_write, 1'b0);
    cyc(); #1; chk3("add_wb", state, 3'd5); chk1("add_wb_rw", reg_write, 1'b1);

    // lw to memory with two wait cycles
    cyc(); instruction = LW_I; #1;
    chk3("lw_if", state, 3'd1); chk1("lw_if_rw", reg_write, 1'b0); chk1("lw_irw", ir_write, 1'b1);
    cyc(); #1; chk3("lw_id", state, 3'd2);
    cyc(); alu_result_high = '0; mem_ready = 1'b0; #1; chk3("lw_exe", state, 3'd3);
    cyc(); #1; chk3("lw_mem1", state, 3'd4); chk1("lw_mem1_rd", mem_read, 1'b1);
    chk1("lw_mem1_iord", io_read, 1'b0);
    cyc(); #1; chk3("lw_mem2", state, 3'd4); chk1("lw_mem2_rd", mem_read, 1'b1);
    cyc(); mem_ready = 1'b1; #1; chk3("lw_mem3", state, 3'd4); chk1("lw_mem3_rd", mem_read, 1'b1);
    chk1("lw_mem3_pcw", pc_write, 1'b0);
    cyc(); mem_ready = 1'b0; #1; chk3("lw_wb", state, 3'd5); chk1("lw_wb_rw", reg_write, 1'b1);
    chk1("lw_wb_rd", mem_read, 1'b0);

    // sw to IO window 0xFFFFFC60
    cyc(); instruction = SW_I; #1; chk3("sw_if", state, 3'd1);
    cyc(); #1; chk3("sw_id", state, 3'd2);
    cyc(); alu_result_high = '1; #1; chk3("sw_exe", state, 3'd3);
    cyc(); #1; chk3("sw_mem", state, 3'd4); chk1("sw_iow", io_write, 1'b1);
    chk1("sw_memw", mem_write, 1'b0); chk1("sw_pcw", pc_write, 1'b1);

    // reserved opcode 0x3F
    cyc(); instruction = RSV_I; #1; chk3("rsv_if", state, 3'd1);
    chk1("sw_iow_off", io_write, 1'b0); chk1("sw_memw_off", mem_write, 1'b0);
    cyc(); #1; chk3("rsv_id", state, 3'd2); chk1("rsv_id_trap", trap, 1'b0);
    cyc(); #1; chk3("rsv_trap", state, 3'd6); chk1("rsv_trap_on", trap, 1'b1);
    chk3("rsv_cause", trap_cause, 3'd3); chk1("rsv_pcw", pc_write, 1'b1);

    // j retires in ID
    cyc(); instruction = J_I; #1; chk3("j_if", state, 3'd1); chk1("rsv_trap_off", trap, 1'b0);
    cyc(); #1; chk3("j_id", state, 3'd2); chk1("j_pcw", pc_write, 1'b1);
    chk1("j_bc", branch_cond, 1'b0);

    // beq retires in EXE with conditional PC load
    cyc(); instruction = BEQ_I; #1; chk3("beq_if", state, 3'd1);
    cyc(); #1; chk3("beq_id", state, 3'd2); chk1("beq_id_pcw", pc_write, 1'b0);
    cyc(); #1; chk3("beq_exe", state, 3'd3); chk1("beq_pcw", pc_write, 1'b1);
    chk1("beq_bc", branch_cond, 1'b1);

    // lw with memory never ready: bus-error trap after MEM_TIMEOUT cycles
    cyc(); instruction = LW_I; alu_result_high = '0; #1;
    chk3("to_if", state, 3'd1); chk1("beq_bc_off", branch_cond, 1'b0);
    cyc(); #1; chk3("to_id", state, 3'd2);
    cyc(); #1; chk3("to_exe", state, 3'd3);
    for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
      cyc(); #1;
      chk3("to_mem_wait", state, 3'd4);
      chk1("to_mem_rw", reg_write, 1'b0);
    end
    cyc(); #1; chk3("to_trap", state, 3'd6); chk3("to_cause", trap_cause, 3'd4);
    chk1("to_trap_rw", reg_write, 1'b0);

    // interrupt raised during add EXE: add writes back, then trap
    cyc(); instruction = ADD_I; #1; chk3("int_if", state, 3'd1); chk1("int_if_rw", reg_write, 1'b0);
    cyc(); #1; chk3("int_id", state, 3'd2);
    cyc(); int_req = IRQ_LINES'(1); int_enable = 1'b1; #1; chk3("int_exe", state, 3'd3);
    cyc(); #1; chk3("int_wb", state, 3'd5); chk1("int_wb_rw", reg_write, 1'b1);
    cyc(); #1; chk3("int_trap", state, 3'd6); chk3("int_cause", trap_cause, 3'd0);
    chk1("int_trap_on", trap, 1'b1); chk1("int_no_fetch", ir_write, 1'b0);

    // syscall beats a still-pending interrupt; STRAP never re-traps
    cyc(); instruction = SYS_I; #1; chk3("sys_if", state, 3'd1); chk1("sys_irw", ir_write, 1'b1);
    cyc(); #1; chk3("sys_id", state, 3'd2);
    cyc(); #1; chk3("sys_trap", state, 3'd6); chk3("sys_cause", trap_cause, 3'd1);

    // eret
    cyc(); int_req = '0; instruction = ERET_I; #1; chk3("eret_if", state, 3'd1);
    cyc(); #1; chk3("eret_id", state, 3'd2); chk1("eret_pulse", eret, 1'b1);
    chk1("eret_pcw", pc_write, 1'b1);

    // reset in the middle of a load
    cyc(); instruction = LW_I; alu_result_high = '0; mem_ready = 1'b0; #1;
    chk3("rst_mid_if", state, 3'd1); chk1("eret_off", eret, 1'b0);
    cyc(); cyc(); cyc(); #1; chk3("rst_mid_mem", state, 3'd4); chk1("rst_mid_rd", mem_read, 1'b1);
    cyc(); reset = 1'b1; #1; chk3("rst_sync_hold", state, 3'd4);
    cyc(); #1; chk3("rst_mid_state", state, 3'd0); chk1("rst_mid_rd_off", mem_read, 1'b0);
    chk1("rst_mid_pcw", pc_write, 1'b0); chk3("rst_mid_cause", trap_cause, 3'd0);
    cyc(); reset = 1'b0; #1; chk3("rst_mid_hold", state, 3'd0);
    cyc(); #1; chk3("rst_mid_if2", state, 3'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
